// File: rtl/i2s_tx.sv
// Philips I2S transmitter: derives MCLK/BCLK/LRCK from iCLK_50 and serialises
// a stereo sample pair that is captured once per frame.
module i2s_tx #(
    parameter int DW        = 16,
    parameter int SLOT      = 32,
    parameter int BCLK_HALF = 8,
    parameter int MCLK_HALF = 1
) (
    input  logic          iCLK_50,
    input  logic          iRESET_n,
    input  logic [DW-1:0] L_data,
    input  logic [DW-1:0] R_data,
    input  logic          mute,
    output logic          oMCLK,
    output logic          oBCLK,
    output logic          oLRCK,
    output logic          oSDIN,
    output logic          frame_start
);

    localparam int FRAME = 2 * SLOT;
    localparam int CW    = $clog2(FRAME);
    localparam int MCW   = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
    localparam int DCW   = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

    localparam logic [CW-1:0]  LAST_C     = CW'(FRAME - 1);
    localparam logic [CW-1:0]  SLOT_C     = CW'(SLOT);
    localparam logic [CW-1:0]  LRCK_ON_C  = CW'(SLOT - 1);
    localparam logic [CW-1:0]  LRCK_OFF_C = CW'(FRAME - 2);
    localparam logic [MCW-1:0] MTC_C      = MCW'(MCLK_HALF - 1);
    localparam logic [DCW-1:0] DTC_C      = DCW'(BCLK_HALF - 1);

    logic [MCW-1:0] r_mcnt;
    logic           r_mclk;
    logic [DCW-1:0] r_div;
    logic           r_bclk;
    logic [CW-1:0]  r_bit_cnt;
    logic           r_lrck;
    logic           r_sdin;
    logic           r_fs;
    logic [DW-1:0]  r_hl;
    logic [DW-1:0]  r_hr;

    logic           w_mtc;
    logic           w_dtc;
    logic           w_fe;
    logic           w_cap;
    logic           w_lr;
    logic           w_left;
    logic [CW-1:0]  w_n;
    logic [CW-1:0]  w_m;
    logic [DW-1:0]  w_word;
    logic [DW-1:0]  w_sh;
    logic           w_sbit;

    assign w_mtc = (r_mcnt == MTC_C);
    assign w_dtc = (r_div == DTC_C);
    assign w_fe  = w_dtc && r_bclk;
    assign w_n   = (r_bit_cnt == LAST_C) ? '0 : r_bit_cnt + CW'(1);
    assign w_cap = w_fe && (w_n == LAST_C);
    assign w_lr  = (w_n >= LRCK_ON_C) && (w_n <= LRCK_OFF_C);

    // Bit position within the slot shifted to the MSB; positions past DW shift
    // everything out, which yields the zero padding for free.
    assign w_left = (w_n < SLOT_C);
    assign w_m    = w_left ? w_n : w_n - SLOT_C;
    assign w_word = w_left ? r_hl : r_hr;
    assign w_sh   = w_word << w_m;
    assign w_sbit = w_sh[DW-1];

    always_ff @(posedge iCLK_50 or negedge iRESET_n) begin
        if (!iRESET_n) begin
            r_mcnt <= '0;
            r_mclk <= 1'b0;
        end else if (w_mtc) begin
            r_mcnt <= '0;
            r_mclk <= ~r_mclk;
        end else begin
            r_mcnt <= r_mcnt + MCW'(1);
        end
    end

    always_ff @(posedge iCLK_50 or negedge iRESET_n) begin
        if (!iRESET_n) begin
            r_div     <= '0;
            r_bclk    <= 1'b0;
            r_bit_cnt <= LAST_C;
            r_lrck    <= 1'b0;
            r_sdin    <= 1'b0;
            r_fs      <= 1'b0;
            r_hl      <= '0;
            r_hr      <= '0;
        end else begin
            r_fs <= w_cap;
            if (w_dtc) begin
                r_div  <= '0;
                r_bclk <= ~r_bclk;
            end else begin
                r_div <= r_div + DCW'(1);
            end
            if (w_fe) begin
                r_bit_cnt <= w_n;
                r_lrck    <= w_lr;
                r_sdin    <= w_sbit;
            end
            if (w_cap) begin
                r_hl <= mute ? '0 : L_data;
                r_hr <= mute ? '0 : R_data;
            end
        end
    end

    assign oMCLK       = r_mclk;
    assign oBCLK       = r_bclk;
    assign oLRCK       = r_lrck;
    assign oSDIN       = r_sdin;
    assign frame_start = r_fs;

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Serialises the core's 16-bit stereo PCM (dac_l/dac_r) into standard Philips I2S for the DECA on-board codec.
- Generates the codec clocks MCLK, BCLK and LRCK from the 50 MHz board clock.
- Sits directly downstream of the core's DAC_L/DAC_R outputs and drives the I2S_MCK/I2S_SCK/I2S_LR/I2S_D pins. The codec SPI configurator sets the codec to I2S slave mode to match.

Parameters:
- DW, 16: sample width in bits.
- SLOT, 32: BCLK periods per channel slot; must be >= DW. Frame length is 2*SLOT.
- BCLK_HALF, 8: iCLK_50 cycles per BCLK half-period; must be >= 1. Defaults give 3.125 MHz BCLK and 48.83 kHz fs.
- MCLK_HALF, 1: iCLK_50 cycles per MCLK half-period; must be >= 1. Default gives 25 MHz MCLK.

Ports:
- iCLK_50  in  1  system clock, 50 MHz.
- iRESET_n  in  1  asynchronous active-low reset.
- L_data  in  DW  left sample, two's complement, synchronous to iCLK_50.
- R_data  in  DW  right sample, two's complement, synchronous to iCLK_50.
- mute  in  1  when high at capture, the frame transmits zeros.
- oMCLK  out  1  codec master clock.
- oBCLK  out  1  I2S bit clock.
- oLRCK  out  1  word select; 0 = left, 1 = right.
- oSDIN  out  1  serial data to codec.
- frame_start  out  1  one-cycle pulse on the cycle the samples are captured.

Behaviour:
- Interface: one clock, iCLK_50. Reset iRESET_n is asynchronous, active-low. Every output is a register; no combinational path from input to output.
- Reset values:
  - oMCLK=0, oBCLK=0, oLRCK=0, oSDIN=0, frame_start=0.
  - MCLK counter=0, BCLK counter=0, bit_cnt=2*SLOT-1.
  - Held L/R sample registers=0.
- MCLK: free-running counter 0..MCLK_HALF-1. On terminal count it wraps and oMCLK toggles. It is independent of the BCLK logic.
- BCLK divider: counter div 0..BCLK_HALF-1. On terminal count it wraps and oBCLK toggles.
- Falling event (FE) = terminal count while oBCLK==1.
- Rising event = terminal count while oBCLK==0. Nothing else updates on a rising event.
- On each FE, in the same clock edge as oBCLK goes to 0:
  - bit_cnt <= (bit_cnt+1) mod 2*SLOT. Call the new value n.
  - oLRCK <= 1 if SLOT-1 <= n <= 2*SLOT-2, else 0. LRCK therefore leads the first data bit of each slot by one BCLK, per I2S.
  - oSDIN, left slot (n < SLOT): hL[DW-1-n] if n < DW, else 0.
  - oSDIN, right slot (n >= SLOT): m = n-SLOT; hR[DW-1-m] if m < DW, else 0. MSB first; unused slot bits are zero-padded.
  - Data changes only on BCLK falling edges and is stable at every rising edge.
- Capture, on the FE where n == 2*SLOT-1 (same edge where oLRCK falls):
  - hL <= mute ? 0 : L_data.
  - hR <= mute ? 0 : R_data.
  - frame_start=1 for exactly that iCLK_50 cycle.
  - Both channels are captured together, so there is no L/R sample skew.
  - Input changes at any other time have no effect until the next capture.
- Post-reset sequence:
  - The first FE gives n=0 and transmits held zeros.
  - The first capture occurs on the FE at the end of frame 0, i.e. 2*SLOT-1 BCLK periods after the first FE. The first non-zero sample is heard in frame 1.
- Reset mid-frame: all state returns to reset values immediately (asynchronous); no partial bit is completed. After release, restart is identical to power-up.
- Mute takes effect only at the capture boundary and never truncates a frame in progress.
- SLOT==DW is legal: no padding bits.

Test Plan:
1. Reset: hold iRESET_n=0 for 10 cycles -> all outputs 0. Release -> first oBCLK rise after 8 cycles, first FE at cycle 16. Assert reset mid-frame -> outputs 0 on the same edge. Resume identically to power-up.
2. Clocking, defaults: oMCLK period 2 clocks; oBCLK period 16 clocks; oLRCK period 64 BCLK (1024 clocks), 50% duty; frame_start period 1024 clocks, single-cycle.
3. Data, defaults: L=16'hA5C3, R=16'h3C5A. Frame 1 bits sampled on BCLK rise -> left slot 1010010111000011 followed by 16 zeros, right slot 0011110001011010 followed by 16 zeros. oLRCK falls one BCLK before left MSB and rises one BCLK before right MSB.
4. Capture isolation: L=16'h8000, R=16'h0001, then change L/R to 16'hFFFF mid-frame -> current frame unchanged, with left MSB only and right LSB at slot bit 15. The new value appears only after the next frame_start.
5. Mute: assert mute between captures with L=R=16'h7FFF -> the frame after the next frame_start is all zeros. Deassert -> 16'h7FFF resumes the following frame.
6. Parameters: DW=16, SLOT=16, BCLK_HALF=1 -> 32-BCLK frame, no padding, BCLK=25 MHz. DW=24, SLOT=32 -> 24 data bits plus 8 zero bits per slot.
